// File: rtl/opb_register_ppc2simulink_if.sv
// OPB slave-side bus bundle for the PPC-to-fabric register.
// Bit numbering follows OPB big-endian convention: index 0 is the MSB.
interface opb_register_ppc2simulink_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_ppc2simulink.sv
// OPB write register feeding user fabric: byte-lane writable DATA word at
// offset 0x0, read-only update counter at 0x4, one-cycle strobe per update.
module opb_register_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst,
    opb_register_ppc2simulink_if.slave    bus,
    output logic [31:0]                   user_data_out,
    output logic                          user_data_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                    state_r;
    logic                      ack_r;
    logic                      valid_r;
    logic [C_OPB_DWIDTH-1:0]   rdata_r;
    logic [31:0]               data_r;
    logic [31:0]               updcnt_r;

    logic [C_OPB_AWIDTH-1:0]   abus_s;
    logic [C_OPB_DWIDTH-1:0]   wdata_s;
    logic [3:0]                be_s;
    logic [C_OPB_AWIDTH:0]     low_diff_s;
    logic [C_OPB_AWIDTH:0]     high_diff_s;
    logic                      in_window_s;
    logic                      hit_s;
    logic [C_OPB_AWIDTH-1:0]   offset_s;
    logic [C_OPB_AWIDTH-3:0]   word_ofs_s;
    logic                      sel_data_s;
    logic                      sel_cnt_s;
    logic                      update_s;
    logic [31:0]               read_mux_s;
    logic                      unused_s;

    // Merge enabled byte lanes of new data into the held word; be[3] is the MS byte.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Leftmost-to-leftmost assignment maps OPB bit 0 onto bit 31.
    assign abus_s  = bus.OPB_ABus;
    assign wdata_s = bus.OPB_DBus;
    assign be_s    = bus.OPB_BE;

    // Window bounds via borrow bits so a zero base does not collapse into a constant compare.
    assign low_diff_s  = {1'b0, abus_s} - {1'b0, C_BASEADDR};
    assign high_diff_s = {1'b0, C_HIGHADDR} - {1'b0, abus_s};
    assign in_window_s = ~low_diff_s[C_OPB_AWIDTH] & ~high_diff_s[C_OPB_AWIDTH];
    assign hit_s       = bus.OPB_select & in_window_s;

    assign offset_s    = abus_s - C_BASEADDR;
    assign word_ofs_s  = offset_s[C_OPB_AWIDTH-1:2];
    assign sel_data_s  = (word_ofs_s == 30'd0);
    assign sel_cnt_s   = (word_ofs_s == 30'd1);
    assign update_s    = sel_data_s & (|be_s);

    assign unused_s = ^{bus.OPB_seqAddr, offset_s[1:0], |C_FAMILY};

    // Read data selection for the mapped offsets.
    always_comb begin
        read_mux_s = 32'h0000_0000;
        if (sel_data_s) begin
            read_mux_s = data_r;
        end else if (sel_cnt_s) begin
            read_mux_s = updcnt_r;
        end else begin
            read_mux_s = 32'h0000_0000;
        end
    end

    // Transfer FSM with registered bus and user outputs; reset wins over any hit.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_r  <= ST_IDLE;
            ack_r    <= 1'b0;
            valid_r  <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            data_r   <= C_INIT_VALUE;
            updcnt_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hit_s) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                        if (bus.OPB_RNW) begin
                            rdata_r <= read_mux_s;
                            valid_r <= 1'b0;
                        end else begin
                            rdata_r <= 32'h0000_0000;
                            if (update_s) begin
                                data_r   <= merge_bytes(data_r, wdata_s, be_s);
                                updcnt_r <= updcnt_r + 32'd1;
                                valid_r  <= 1'b1;
                            end else begin
                                valid_r  <= 1'b0;
                            end
                        end
                    end else begin
                        ack_r   <= 1'b0;
                        valid_r <= 1'b0;
                        rdata_r <= 32'h0000_0000;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_GAP;
                    ack_r   <= 1'b0;
                    valid_r <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
                ST_GAP: begin
                    // Select may still be high from the finished transfer; ignore it here.
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    valid_r <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    valid_r <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign bus.Sl_DBus     = rdata_r;
    assign bus.Sl_xferAck  = ack_r;
    assign bus.Sl_errAck   = 1'b0;
    assign bus.Sl_retry    = 1'b0;
    assign bus.Sl_toutSup  = 1'b0;
    assign user_data_out   = data_r;
    assign user_data_valid = valid_r;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Scoreboard bench for opb_register_ppc2simulink: stimulus pushes expected
// acks into a queue, a negedge monitor pops and compares them.
module tb_opb_register_ppc2simulink;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] HIGH = 32'h8000_00FF;
    localparam logic [31:0] INIT = 32'hDEAD_BEEF;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        logic        valid;
        logic [31:0] udo;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] user_data_out;
    logic        user_data_valid;
    int          cyc;
    int          n_tests;
    int          n_fail;
    exp_t        q[$];

    opb_register_ppc2simulink_if bus();

    opb_register_ppc2simulink #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex5"),
        .C_INIT_VALUE (INIT)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst         (rst),
        .bus             (bus.slave),
        .user_data_out   (user_data_out),
        .user_data_valid (user_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every negedge, either score an ack against the queue or check idle outputs.
    always @(negedge clk) begin
        logic [31:0] dbus;
        exp_t e;
        dbus = bus.Sl_DBus;
        check("tied_zero", {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
        if (bus.Sl_xferAck === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check({e.name, "_latency"}, e.cyc, cyc);
                check({e.name, "_valid"}, {31'd0, user_data_valid}, {31'd0, e.valid});
                check({e.name, "_udo"}, user_data_out, e.udo);
                if (e.is_read) check({e.name, "_rdata"}, dbus, e.rdata);
            end
        end else begin
            check("idle_dbus", dbus, 32'd0);
            check("idle_valid", {31'd0, user_data_valid}, 32'd0);
        end
    end

    task automatic xfer(input string name, input logic rnw, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata, input logic exp_ack,
                        input logic [31:0] exp_rdata, input logic exp_valid,
                        input logic [31:0] exp_udo);
        exp_t e;
        bit seen;
        @(negedge clk);
        bus.OPB_ABus   = addr;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = wdata;
        bus.OPB_RNW    = rnw;
        bus.OPB_select = 1'b1;
        if (exp_ack) begin
            e.is_read = rnw;
            e.rdata   = exp_rdata;
            e.valid   = exp_valid;
            e.udo     = exp_udo;
            e.cyc     = cyc + 1;
            e.name    = name;
            q.push_back(e);
        end
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (bus.Sl_xferAck === 1'b1) seen = 1'b1;
        end
        if (exp_ack && !seen) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            void'(q.pop_front());
        end
        bus.OPB_select = 1'b0;
        bus.OPB_DBus   = 32'd0;
        @(negedge clk);
    endtask

    initial begin
        cyc = 0;
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.OPB_ABus = 32'd0;
        bus.OPB_BE = 4'd0;
        bus.OPB_DBus = 32'd0;
        bus.OPB_RNW = 1'b0;
        bus.OPB_select = 1'b0;
        bus.OPB_seqAddr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_udo", user_data_out, INIT);
        rst = 1'b0;

        xfer("rd_data_rst", 1'b1, BASE,        4'hF, 32'd0, 1'b1, INIT, 1'b0, INIT);
        xfer("rd_cnt_rst",  1'b1, BASE + 32'd4, 4'hF, 32'd0, 1'b1, 32'd0, 1'b0, INIT);
        xfer("wr_full",     1'b0, BASE, 4'hF, 32'h1234_5678, 1'b1, 32'd0, 1'b1, 32'h1234_5678);
        xfer("rd_cnt_1",    1'b1, BASE + 32'd4, 4'hF, 32'd0, 1'b1, 32'd1, 1'b0, 32'h1234_5678);
        xfer("wr_be0101",   1'b0, BASE, 4'b0101, 32'hAAAA_AAAA, 1'b1, 32'd0, 1'b1, 32'h12AA_56AA);
        xfer("wr_be0000",   1'b0, BASE, 4'b0000, 32'h5555_5555, 1'b1, 32'd0, 1'b0, 32'h12AA_56AA);
        xfer("rd_cnt_2",    1'b1, BASE + 32'd4, 4'h0, 32'd0, 1'b1, 32'd2, 1'b0, 32'h12AA_56AA);
        xfer("wr_unmapped", 1'b0, BASE + 32'd8, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 32'h12AA_56AA);
        xfer("rd_unmapped", 1'b1, BASE + 32'd8, 4'hF, 32'd0, 1'b1, 32'd0, 1'b0, 32'h12AA_56AA);
        xfer("rd_data",     1'b1, BASE, 4'hF, 32'd0, 1'b1, 32'h12AA_56AA, 1'b0, 32'h12AA_56AA);
        xfer("rd_top",      1'b1, HIGH - 32'd3, 4'hF, 32'd0, 1'b1, 32'd0, 1'b0, 32'h12AA_56AA);
        xfer("rd_above",    1'b1, HIGH + 32'd1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        xfer("wr_below",    1'b0, BASE - 32'd4, 4'hF, 32'h0BAD_0BAD, 1'b0, 32'd0, 1'b0, 32'd0);
        xfer("rd_cnt_still2", 1'b1, BASE + 32'd4, 4'hF, 32'd0, 1'b1, 32'd2, 1'b0, 32'h12AA_56AA);

        // Counter wrap: preload the counter to all ones.
        @(negedge clk);
        force dut.updcnt_r = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.updcnt_r;
        xfer("wr_wrap",     1'b0, BASE, 4'hF, 32'h0F0F_0F0F, 1'b1, 32'd0, 1'b1, 32'h0F0F_0F0F);
        xfer("rd_cnt_wrap", 1'b1, BASE + 32'd4, 4'hF, 32'd0, 1'b1, 32'd0, 1'b0, 32'h0F0F_0F0F);

        // Reset on the edge that would enter ACK: the monitor flags any ack as unexpected.
        @(negedge clk);
        bus.OPB_ABus   = BASE;
        bus.OPB_BE     = 4'hF;
        bus.OPB_DBus   = 32'h7777_7777;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_select = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.OPB_select = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_udo", user_data_out, INIT);
        xfer("wr_after_rst", 1'b0, BASE, 4'hF, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b1, 32'hCAFE_F00D);
        xfer("rd_cnt_after", 1'b1, BASE + 32'd4, 4'hF, 32'd0, 1'b1, 32'd1, 1'b0, 32'hCAFE_F00D);

        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
